sn_to_bn_counter: RTL and testbench

// Stochastic-to-binary converter: the receive end of the SNG bitstream interface.

---
 rtl/sn_to_bn_counter.sv | 112 +++++++++++
 tb/tb_sn_to_bn_counter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sn_to_bn_counter.sv
// sn_to_bn_counter: stochastic-to-binary converter; counts the ones in one
// fixed-length stochastic bitstream window and returns the binary magnitude.
//
// Ports:
//   i_clk_s2b    clock, all logic on posedge
//   i_rst_s2b    asynchronous active-high reset
//   i_start_s2b  begin a new window (sampled in IDLE only)
//   i_stop_s2b   abort the current window (beats start and the final bit)
//   i_sn_valid   i_sn_bit carries a stream bit this cycle
//   i_sn_bit     stochastic stream bit
//   o_busy       high while a window is being accumulated
//   o_done       one-cycle pulse, result registers updated
//   o_ones       raw ones count of the last completed window
//   o_x_bn       o_ones saturated to 2^OUT_W-1
module sn_to_bn_counter #(
    parameter int STREAM_LEN = 16,
    parameter int CNT_W      = $clog2(STREAM_LEN + 1),
    parameter int OUT_W      = 4
) (
    input  logic             i_clk_s2b,
    input  logic             i_rst_s2b,
    input  logic             i_start_s2b,
    input  logic             i_stop_s2b,
    input  logic             i_sn_valid,
    input  logic             i_sn_bit,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_ones,
    output logic [OUT_W-1:0] o_x_bn
);

    localparam int SAT_MAX = (1 << OUT_W) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx;
    logic [CNT_W-1:0] ones_r;
    logic [CNT_W-1:0] ones_nx;
    logic [CNT_W-1:0] bits_r;
    logic [CNT_W-1:0] bits_nx;
    logic [OUT_W-1:0] x_sat;

    always_comb begin
        state_nx = state_r;
        ones_nx  = ones_r;
        bits_nx  = bits_r;
        case (state_r)
            IDLE: begin
                // Stop beats start; stream bits of the start cycle are dropped.
                if (i_start_s2b && !i_stop_s2b) begin
                    ones_nx  = '0;
                    bits_nx  = '0;
                    state_nx = ACC;
                end
            end
            ACC: begin
                if (i_stop_s2b) begin
                    state_nx = IDLE;
                end else if (i_sn_valid) begin
                    bits_nx = bits_r + CNT_W'(1);
                    ones_nx = ones_r + CNT_W'(i_sn_bit);
                    // This accept is the last bit of the window.
                    if (bits_r == CNT_W'(STREAM_LEN - 1)) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        x_sat = OUT_W'(ones_r);
        if (32'(ones_r) > SAT_MAX) begin
            x_sat = OUT_W'(SAT_MAX);
        end
    end

    always_ff @(posedge i_clk_s2b or posedge i_rst_s2b) begin
        if (i_rst_s2b) begin
            state_r <= IDLE;
            ones_r  <= '0;
            bits_r  <= '0;
            o_done  <= 1'b0;
            o_ones  <= '0;
            o_x_bn  <= '0;
        end else begin
            state_r <= state_nx;
            ones_r  <= ones_nx;
            bits_r  <= bits_nx;
            // Result and pulse land together on the edge that leaves DONE.
            o_done  <= (state_r == DONE);
            if (state_r == DONE) begin
                o_ones <= ones_r;
                o_x_bn <= x_sat;
            end
        end
    end

    assign o_busy = (state_r == ACC);

endmodule

// File: tb/tb_sn_to_bn_counter.sv
// tb_sn_to_bn_counter: directed self-checking bench for sn_to_bn_counter.
//
// Ports: none (top-level bench).
module tb_sn_to_bn_counter;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       valid;
    logic       sbit;
    logic       busy;
    logic       done;
    logic [4:0] ones;
    logic [3:0] xbn;

    int n_cmp;
    int n_err;
    int lat;
    logic [15:0] pat;

    sn_to_bn_counter dut (
        .i_clk_s2b   (clk),
        .i_rst_s2b   (rst),
        .i_start_s2b (start),
        .i_stop_s2b  (stop),
        .i_sn_valid  (valid),
        .i_sn_bit    (sbit),
        .o_busy      (busy),
        .o_done      (done),
        .o_ones      (ones),
        .o_x_bn      (xbn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one window; start_at >= 0 also raises start alongside that bit.
    task automatic window(input logic [15:0] p, input bit gaps,
                          input int start_at, output int edges);
        bit seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        for (int i = 0; i < 16; i++) begin
            if (gaps && i > 0) begin
                valid = 1'b0;
                sbit  = 1'b1;
                tick();
                edges++;
            end
            valid = 1'b1;
            sbit  = p[i];
            start = (i == start_at);
            tick();
            edges++;
        end
        valid = 1'b0;
        sbit  = 1'b0;
        start = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            edges++;
            seen = done;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        valid = 1'b0;
        sbit  = 1'b0;
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ones", 32'(ones), 32'd0);
        chk("rst_xbn", 32'(xbn), 32'd0);
        rst = 1'b0;
        tick();

        // all-ones window saturates o_x_bn; busy during window
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy_acc", 32'(busy), 32'd1);
        valid = 1'b1;
        sbit  = 1'b1;
        repeat (16) tick();
        valid = 1'b0;
        chk("t1_no_early_done", 32'(done), 32'd0);
        tick();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_ones", 32'(ones), 32'd16);
        chk("t1_xbn", 32'(xbn), 32'd15);
        tick();
        chk("t1_pulse_1cyc", 32'(done), 32'd0);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // alternating pattern, minimum latency, then all-zero back-to-back
        window(16'hAAAA, 1'b0, -1, lat);
        chk("t2_lat", 32'(lat), 32'd17);
        chk("t2_ones", 32'(ones), 32'd8);
        chk("t2_xbn", 32'(xbn), 32'd8);
        window(16'h0000, 1'b0, -1, lat);
        chk("t2_zero_ones", 32'(ones), 32'd0);
        chk("t2_zero_xbn", 32'(xbn), 32'd0);

        // gaps every other cycle
        window(16'hFFFF, 1'b1, -1, lat);
        chk("t3_lat", 32'(lat), 32'd32);
        chk("t3_ones", 32'(ones), 32'd16);

        // abort keeps the previous result
        window(16'h001F, 1'b0, -1, lat);
        chk("t4_ones5", 32'(ones), 32'd5);
        pat = 16'h017F;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            valid = 1'b1;
            sbit  = pat[i];
            tick();
        end
        stop  = 1'b1;
        sbit  = 1'b1;
        tick();
        stop  = 1'b0;
        valid = 1'b0;
        chk("t4_idle", 32'(busy), 32'd0);
        tick();
        chk("t4_no_done", 32'(done), 32'd0);
        chk("t4_ones_kept", 32'(ones), 32'd5);
        chk("t4_xbn_kept", 32'(xbn), 32'd5);
        window(16'h0F0F, 1'b0, -1, lat);
        chk("t4_fresh", 32'(ones), 32'd8);

        // stop beats the final bit
        start = 1'b1;
        tick();
        start = 1'b0;
        valid = 1'b1;
        sbit  = 1'b1;
        repeat (15) tick();
        stop = 1'b1;
        tick();
        stop  = 1'b0;
        valid = 1'b0;
        tick();
        chk("t4_stop_last_done", 32'(done), 32'd0);
        chk("t4_stop_last_ones", 32'(ones), 32'd8);

        // start inside a window is ignored
        window(16'h00FF, 1'b0, 5, lat);
        chk("t5_midstart_lat", 32'(lat), 32'd17);
        chk("t5_midstart_ones", 32'(ones), 32'd8);

        // start with stop stays idle
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_startstop", 32'(busy), 32'd0);

        // async reset mid-window clears outputs without a clock edge
        start = 1'b1;
        tick();
        start = 1'b0;
        valid = 1'b1;
        sbit  = 1'b1;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ones", 32'(ones), 32'd0);
        chk("t5_rst_xbn", 32'(xbn), 32'd0);
        valid = 1'b0;
        sbit  = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // loopback from a comparator SNG with a permuted 4-bit ramp
        for (int x = 0; x < 16; x++) begin
            for (int k = 0; k < 16; k++) begin
                pat[k] = (((k * 7 + 3) % 16) < x);
            end
            window(pat, 1'b0, -1, lat);
            chk($sformatf("t6_xbn_%0d", x), 32'(xbn), 32'(x));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
